// File: rtl/m16_bank_fill_sched.sv
// Write-side scheduler for the M16 double-buffered sample memory: round-robin
// arbitration of sample channels into the bank the serializer is not reading.
module m16_bank_fill_sched #(
  parameter int NCH = 4,
  parameter int AW  = 7,
  parameter int DW  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic [NCH-1:0]    iReq,
  input  logic [NCH*DW-1:0] iData,
  output logic [NCH-1:0]    oGnt,
  output logic              oWrEn,
  output logic [AW:0]       oWrAddr,
  output logic [DW-1:0]     oWrData,
  output logic              oFull,
  output logic              oUnderrun,
  output logic [7:0]        oUnderCnt,
  output logic [AW:0]       oFillLevel
);

  localparam int          CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {ST_SYNC, ST_FILL, ST_FULL} state_t;

  state_t            r_state;
  logic              r_sw_prev;
  logic [AW:0]       r_wr_ptr;
  logic [CW-1:0]     r_rr_last;
  logic [NCH-1:0]    r_gnt;
  logic              r_wr_en;
  logic [AW:0]       r_wr_addr;
  logic [DW-1:0]     r_wr_data;
  logic              r_full;
  logic              r_underrun;
  logic [7:0]        r_under_cnt;

  logic              w_sw_edge;
  logic [NCH-1:0]    w_elig;
  logic              w_found;
  logic [CW-1:0]     w_winner;
  logic [NCH-1:0]    w_onehot;
  logic [DW-1:0]     w_ch_data [NCH];

  assign w_sw_edge = (iSwitch != r_sw_prev);
  // The current grant holder is masked so a held request is not granted twice.
  assign w_elig    = iReq & ~r_gnt;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_ch_data[gi] = iData[gi*DW +: DW];
      assign w_onehot[gi]  = (w_winner == CW'(gi));
    end
  endgenerate

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!w_found && w_elig[CW'((int'(r_rr_last) + i) % NCH)]) begin
        w_found  = 1'b1;
        w_winner = CW'((int'(r_rr_last) + i) % NCH);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SYNC;
      r_sw_prev   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rr_last   <= CW'(NCH - 1);
      r_gnt       <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_full      <= 1'b0;
      r_underrun  <= 1'b0;
      r_under_cnt <= '0;
    end else begin
      r_sw_prev  <= iSwitch;
      r_gnt      <= '0;
      r_wr_en    <= 1'b0;
      r_underrun <= 1'b0;
      case (r_state)
        ST_SYNC: begin
          if (w_sw_edge) begin
            r_state  <= ST_FILL;
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
          end
        end
        ST_FILL, ST_FULL: begin
          // A bank toggle beats any pending request in the same cycle.
          if (w_sw_edge) begin
            if (r_wr_ptr < DEPTH) begin
              r_underrun <= 1'b1;
              if (r_under_cnt != 8'hFF) r_under_cnt <= r_under_cnt + 8'd1;
            end
            r_wr_ptr <= '0;
            r_full   <= 1'b0;
            r_state  <= ST_FILL;
          end else if (r_state == ST_FILL && w_found) begin
            r_gnt     <= w_onehot;
            r_wr_en   <= 1'b1;
            r_wr_addr <= {~iSwitch, r_wr_ptr[AW-1:0]};
            r_wr_data <= w_ch_data[w_winner];
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_rr_last <= w_winner;
            if (r_wr_ptr == DEPTH - 1'b1) begin
              r_state <= ST_FULL;
              r_full  <= 1'b1;
            end
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign oGnt       = r_gnt;
  assign oWrEn      = r_wr_en;
  assign oWrAddr    = r_wr_addr;
  assign oWrData    = r_wr_data;
  assign oFull      = r_full;
  assign oUnderrun  = r_underrun;
  assign oUnderCnt  = r_under_cnt;
  assign oFillLevel = r_wr_ptr;

endmodule

// File: tb/tb_m16_bank_fill_sched.sv
// Bench for m16_bank_fill_sched: behavioural model pushes expected writes to a
// queue, a negedge monitor pops and compares; scenario tasks add direct checks.
module tb_m16_bank_fill_sched;

  localparam int NCH = 4;
  localparam int AW  = 7;
  localparam int DW  = 12;

  logic              clk;
  logic              rst_n;
  logic              iSwitch;
  logic [NCH-1:0]    iReq;
  logic [NCH*DW-1:0] iData;
  logic [NCH-1:0]    oGnt;
  logic              oWrEn;
  logic [AW:0]       oWrAddr;
  logic [DW-1:0]     oWrData;
  logic              oFull;
  logic              oUnderrun;
  logic [7:0]        oUnderCnt;
  logic [AW:0]       oFillLevel;

  int checks = 0;
  int errors = 0;

  m16_bank_fill_sched #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(rst_n), .iSwitch(iSwitch), .iReq(iReq), .iData(iData),
    .oGnt(oGnt), .oWrEn(oWrEn), .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oFull(oFull), .oUnderrun(oUnderrun), .oUnderCnt(oUnderCnt),
    .oFillLevel(oFillLevel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [NCH-1:0] gnt;
    logic [AW:0]    addr;
    logic [DW-1:0]  data;
  } wr_t;

  wr_t            q[$];
  wr_t            m_e;
  wr_t            m_got;
  int             m_state;   // 0 sync, 1 fill, 2 full
  logic           m_prev;
  int             m_ptr;
  int             m_rr;
  int             m_cnt;
  logic           m_under;
  logic [NCH-1:0] m_gnt;
  logic [NCH-1:0] m_gnt_new;
  logic [NCH-1:0] m_elig;
  logic           m_edge;
  logic           m_found;
  int             m_k;
  int             m_w;
  logic [7:0]     cnt [NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_prev = 1'b0; m_ptr = 0; m_rr = NCH - 1; m_cnt = 0;
      m_under = 1'b0; m_gnt = '0;
      q.delete();
    end else begin
      m_under   = 1'b0;
      m_gnt_new = '0;
      m_edge    = (iSwitch != m_prev);
      m_prev    = iSwitch;
      if (m_state == 0) begin
        if (m_edge) begin m_state = 1; m_ptr = 0; end
      end else if (m_edge) begin
        if (m_ptr < 128) begin
          m_under = 1'b1;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
        m_ptr = 0; m_state = 1;
      end else if (m_state == 1) begin
        m_elig  = iReq & ~m_gnt;
        m_found = 1'b0;
        m_w     = 0;
        for (int i = 1; i <= NCH; i++) begin
          m_k = (m_rr + i) % NCH;
          if (!m_found && m_elig[m_k]) begin m_found = 1'b1; m_w = m_k; end
        end
        if (m_found) begin
          m_gnt_new  = '0;
          m_gnt_new[m_w] = 1'b1;
          m_e.gnt  = m_gnt_new;
          m_e.addr = {~iSwitch, 7'(m_ptr)};
          m_e.data = iData[m_w*DW +: DW];
          q.push_back(m_e);
          m_ptr = m_ptr + 1;
          m_rr  = m_w;
          if (m_ptr == 128) m_state = 2;
        end
      end
      m_gnt = m_gnt_new;
    end
  end

  // Monitor: compares status against the model and pops expected writes.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (oUnderrun !== m_under) begin
        errors++; $display("FAIL mon_underrun got=%b exp=%b", oUnderrun, m_under);
      end
      checks++;
      if (oUnderCnt !== 8'(m_cnt)) begin
        errors++; $display("FAIL mon_undercnt got=%0d exp=%0d", oUnderCnt, m_cnt);
      end
      checks++;
      if (oFillLevel !== 8'(m_ptr)) begin
        errors++; $display("FAIL mon_fill got=%0d exp=%0d", oFillLevel, m_ptr);
      end
      checks++;
      if (oFull !== (m_state == 2)) begin
        errors++; $display("FAIL mon_full got=%b exp=%b", oFull, (m_state == 2));
      end
      if (oWrEn === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got gnt=%b addr=%h data=%h exp none", oGnt, oWrAddr, oWrData);
        end else begin
          m_got = q.pop_front();
          if ({oGnt, oWrAddr, oWrData} !== {m_got.gnt, m_got.addr, m_got.data}) begin
            errors++;
            $display("FAIL write got gnt=%b addr=%h data=%h exp gnt=%b addr=%h data=%h",
                     oGnt, oWrAddr, oWrData, m_got.gnt, m_got.addr, m_got.data);
          end else begin
            $display("WR gnt=%b addr=%h data=%h", oGnt, oWrAddr, oWrData);
          end
        end
      end else begin
        checks++;
        if (q.size() != 0 || oGnt !== '0) begin
          errors++;
          $display("FAIL missing_write got wren=%b gnt=%b exp pending=%0d", oWrEn, oGnt, q.size());
          q.delete();
        end
      end
      for (int k = 0; k < NCH; k++) if (oGnt[k] === 1'b1) cnt[k] = cnt[k] + 8'd1;
    end
    for (int k = 0; k < NCH; k++) iData[k*DW +: DW] = {4'(k), cnt[k]};
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; iSwitch = 1'b0; iReq = '0;
    for (int k = 0; k < NCH; k++) cnt[k] = 8'(k * 16);
    repeat (3) @(negedge clk);
    checks++;
    if ({oGnt, oWrEn, oWrAddr, oWrData, oFull, oUnderrun, oUnderCnt, oFillLevel} !== '0) begin
      errors++; $display("FAIL reset_outputs got gnt=%b wren=%b fill=%0d exp all zero", oGnt, oWrEn, oFillLevel);
    end
    rst_n = 1'b1;
    iReq  = '1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (oWrEn !== 1'b0) begin errors++; $display("FAIL sync_no_write got wren=%b exp 0", oWrEn); end
    end
    iReq    = '0;
    iSwitch = 1'b1;
    @(negedge clk);
    checks++;
    if (oUnderrun !== 1'b0 || oFillLevel !== 8'd0) begin
      errors++; $display("FAIL first_sync got under=%b fill=%0d exp 0 0", oUnderrun, oFillLevel);
    end
  endtask

  task automatic test_round_robin();
    int n = 0;
    logic [NCH-1:0] eg;
    iReq = '1;
    for (int c = 0; c < 300 && n < 128; c++) begin
      @(negedge clk);
      if (oWrEn === 1'b1) begin
        eg = '0; eg[n % NCH] = 1'b1;
        checks++;
        if (oGnt !== eg || oWrAddr !== 8'(n)) begin
          errors++; $display("FAIL rr_order got gnt=%b addr=%h exp gnt=%b addr=%h", oGnt, oWrAddr, eg, 8'(n));
        end
        n++;
      end
    end
    checks++;
    if (n != 128 || oFull !== 1'b1 || oFillLevel !== 8'd128) begin
      errors++; $display("FAIL rr_full got n=%0d full=%b fill=%0d exp 128 1 128", n, oFull, oFillLevel);
    end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (oGnt !== '0) begin errors++; $display("FAIL full_no_grant got gnt=%b exp 0", oGnt); end
    end
    iReq = '0;
  endtask

  task automatic test_single_channel();
    logic prev = 1'b0;
    logic seen = 1'b0;
    int   g = 0;
    iSwitch = 1'b0;
    @(negedge clk);
    iReq = 4'b0100;
    repeat (40) begin
      @(negedge clk);
      checks++;
      if (prev && oGnt[2]) begin errors++; $display("FAIL ch2_consecutive got gnt=%b exp 0000", oGnt); end
      else if (seen && !prev && !oGnt[2]) begin errors++; $display("FAIL ch2_gap got gnt=%b exp 0100", oGnt); end
      if (oGnt[2]) begin seen = 1'b1; g++; end
      prev = oGnt[2];
    end
    checks++;
    if (g != 20) begin errors++; $display("FAIL ch2_rate got %0d exp 20", g); end
    iReq = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun();
    iReq = '1;
    for (int c = 0; c < 200 && oFillLevel < 8'd50; c++) @(negedge clk);
    iReq    = '0;
    iSwitch = ~iSwitch;
    @(negedge clk);
    checks++;
    if (oUnderrun !== 1'b1 || oUnderCnt !== 8'd1 || oWrEn !== 1'b0 || oFillLevel !== 8'd0) begin
      errors++; $display("FAIL underrun_pulse got under=%b cnt=%0d wren=%b fill=%0d exp 1 1 0 0",
                         oUnderrun, oUnderCnt, oWrEn, oFillLevel);
    end
    iReq = 4'b0010;
    @(negedge clk);
    iReq = '0;
    checks++;
    if (oWrEn !== 1'b1 || oGnt !== 4'b0010 || oWrAddr !== {~iSwitch, 7'd0} || oUnderrun !== 1'b0) begin
      errors++; $display("FAIL new_bank_first got wren=%b gnt=%b addr=%h under=%b exp 1 0010 %h 0",
                         oWrEn, oGnt, oWrAddr, oUnderrun, {~iSwitch, 7'd0});
    end
    for (int r = 0; r < 299; r++) begin
      @(negedge clk);
      iSwitch = ~iSwitch;
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (oUnderCnt !== 8'd255) begin errors++; $display("FAIL undercnt_sat got %0d exp 255", oUnderCnt); end
  endtask

  task automatic test_switch_with_req();
    iSwitch = ~iSwitch;
    iReq    = 4'b1010;
    @(negedge clk);
    checks++;
    if (oWrEn !== 1'b0 || oGnt !== '0 || oUnderrun !== 1'b1) begin
      errors++; $display("FAIL switch_priority got wren=%b gnt=%b under=%b exp 0 0000 1", oWrEn, oGnt, oUnderrun);
    end
    @(negedge clk);
    checks++;
    if (oGnt !== 4'b1000 || oWrAddr !== {~iSwitch, 7'd0}) begin
      errors++; $display("FAIL switch_grant got gnt=%b addr=%h exp 1000 %h", oGnt, oWrAddr, {~iSwitch, 7'd0});
    end
    iReq = 4'b0010;
    @(negedge clk);
    checks++;
    if (oGnt !== 4'b0010 || oWrAddr !== {~iSwitch, 7'd1}) begin
      errors++; $display("FAIL switch_next got gnt=%b addr=%h exp 0010 %h", oGnt, oWrAddr, {~iSwitch, 7'd1});
    end
    iReq = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midfill();
    iReq = '1;
    for (int c = 0; c < 200 && oFillLevel < 8'd70; c++) @(negedge clk);
    checks++;
    if (oFillLevel !== 8'd70) begin errors++; $display("FAIL midfill_level got %0d exp 70", oFillLevel); end
    rst_n = 1'b0;
    iReq  = '0;
    #1;
    checks++;
    if ({oGnt, oWrEn, oWrAddr, oWrData, oFull, oUnderrun, oUnderCnt, oFillLevel} !== '0) begin
      errors++; $display("FAIL async_reset got gnt=%b wren=%b cnt=%0d fill=%0d exp all zero",
                         oGnt, oWrEn, oUnderCnt, oFillLevel);
    end
    iSwitch = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    iReq  = '1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (oWrEn !== 1'b0 || oUnderCnt !== 8'd0) begin
        errors++; $display("FAIL post_reset_idle got wren=%b cnt=%0d exp 0 0", oWrEn, oUnderCnt);
      end
    end
    iSwitch = 1'b1;
    @(negedge clk);
    checks++;
    if (oWrEn !== 1'b0 || oUnderrun !== 1'b0) begin
      errors++; $display("FAIL post_reset_sync got wren=%b under=%b exp 0 0", oWrEn, oUnderrun);
    end
    @(negedge clk);
    iReq = '0;
    checks++;
    if (oGnt !== 4'b0001 || oWrAddr !== 8'h00) begin
      errors++; $display("FAIL post_reset_first got gnt=%b addr=%h exp 0001 00", oGnt, oWrAddr);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_channel();
    test_underrun();
    test_switch_with_req();
    test_reset_midfill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m16_bank_fill_sched.md
Name: m16_bank_fill_sched

Overview:
- Write-side scheduler for the double-buffered 2x128-word sample memory that the M16 frame serializer reads.
- Arbitrates NCH sample-producing channels round-robin and writes granted 12-bit samples into the bank the serializer is not currently reading.
- Tracks fill level and realigns to the serializer's bank toggle (iSwitch).
- Flags and counts banks that were not completely filled before the serializer switched to them.

Parameters:
NCH, 4, number of requesting channels (2..8)
AW, 7, word address width within one bank (128 words)
DW, 12, sample width

Ports:
clk  in  1  system clock (same domain as serializer)
reset  in  1  asynchronous, active-low
iSwitch  in  1  serializer bank select; serializer reads bank iSwitch, this block fills bank ~iSwitch
iReq  in  NCH  per-channel request; held high with stable data until granted
iData  in  NCH*DW  channel k sample at bits [k*DW +: DW]
oGnt  out  NCH  one-hot grant pulse, one cycle per accepted sample
oWrEn  out  1  memory write strobe
oWrAddr  out  AW+1  {bank, word address}
oWrData  out  DW  sample written
oFull  out  1  target bank holds 2^AW words
oUnderrun  out  1  one-cycle pulse: switch occurred with bank not full
oUnderCnt  out  8  saturating count of underruns
oFillLevel  out  AW+1  words written into current target bank (0..128)

Behaviour:
- Reset (async, reset=0): all outputs 0; state SYNC; swPrev=0; wrPtr=0; rrLast=NCH-1 (so ch0 wins first arbitration).
- swEdge = (iSwitch != swPrev); swPrev <= iSwitch every cycle.
- States:
  - SYNC: no grants or writes. On swEdge -> FILL, wrPtr=0, bank = ~iSwitch. This aligns the first fill to a bank boundary.
  - FILL: each cycle without swEdge, eligible = iReq & ~oGnt. The current grant holder is masked so a held request is not double-granted.
    - If eligible != 0, pick the first set bit searching from (rrLast+1) mod NCH upward with wrap.
    - Registered next edge: oGnt = onehot(winner); oWrEn=1; oWrAddr={~iSwitch, wrPtr[AW-1:0]}; oWrData=iData[winner]; wrPtr+1; rrLast=winner.
    - Otherwise oGnt=0, oWrEn=0.
    - When wrPtr reaches 2^AW -> FULL.
  - FULL: oFull=1; no grants; requests stay pending.
- On swEdge in FILL or FULL:
  - If wrPtr < 2^AW: oUnderrun=1 for one cycle and oUnderCnt+1, saturating at 255.
  - Then wrPtr=0, oFull=0, state FILL, new bank = ~iSwitch.
  - No grant or write in the swEdge cycle: switch has priority over requests.
  - Words not written in the abandoned bank keep stale content; no padding is done.
- A write issued on the edge before swEdge is detected lands in the old bank and counts toward that bank's fill.
- oFillLevel mirrors wrPtr (registered); it equals 128 exactly when oFull=1.
- Latency: request sampled at edge n -> oGnt/oWrEn/oWrData valid after edge n, i.e. one cycle. The requester may update iData/iReq on the edge where it sees oGnt.
- Maximum throughput is one write per cycle across all channels. A single channel can win at most every second cycle when it is the only requester, because of the grant mask.
- Reset mid-fill: immediate return to SYNC; the partially written bank is discarded silently, no underrun is reported.

Test Plan:
1. Reset, iReq=0, toggle iSwitch 0->1: state enters FILL; no writes before the toggle; oUnderrun=0 (no prior bank).
2. All 4 iReq held high continuously after sync with iSwitch=1: grants go ch0,ch1,ch2,ch3,ch0...; oWrAddr 0x00..0x7F with bank bit 0; after 128 writes oFull=1, oFillLevel=128, no further oGnt.
3. Only ch2 requesting, holding until granted, then immediately re-requesting: oGnt[2] pulses every second cycle; never two consecutive cycles.
4. Fill 50 words, then toggle iSwitch: oUnderrun one-cycle pulse; oUnderCnt=1; no write in the toggle cycle; next write at word 0 of the opposite bank. Repeat 300 times: oUnderCnt saturates at 255.
5. iSwitch toggles in the same cycle as a pending iReq: no grant that cycle; grant on the following cycle to the expected round-robin winner at address 0 of the new bank.
6. Assert reset at wrPtr=70: all outputs 0 asynchronously; after release no writes until the next iSwitch edge; oUnderCnt=0.
